// File: rtl/seg7_pkg.sv
// Shared constants for the stopwatch seven-segment display driver.
// Segment patterns are {g,f,e,d,c,b,a}, and all of them are active-low.
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_BLANK = 7'b1111111;

   localparam logic [1:0] DIG_SEC0 = 2'd0;
   localparam logic [1:0] DIG_SEC1 = 2'd1;
   localparam logic [1:0] DIG_MIN0 = 2'd2;
   localparam logic [1:0] DIG_MIN1 = 2'd3;

   // One-hot-low anode pattern for a digit index.
   function automatic logic [3:0] anode_for(input logic [1:0] idx);
      logic [3:0] an;
      an = 4'b1111;
      unique case (idx)
         DIG_SEC0: an = 4'b1110;
         DIG_SEC1: an = 4'b1101;
         DIG_MIN0: an = 4'b1011;
         DIG_MIN1: an = 4'b0111;
         default:  an = 4'b1111;
      endcase
      return an;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decoder from BCD to active-low seven-segment patterns.
// Codes 10-15 produce a blank digit.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_display_mux.sv
// Time-multiplexed 4-digit display driver. It takes a frame snapshot so the digits do not tear.
// Defining SEG7_BLINK_EN adds blinking of the minutes or seconds pair in adjust mode.
module seg7_display_mux
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min1,
   input  logic [3:0] min0,
   input  logic [3:0] sec1,
   input  logic [3:0] sec0,
   input  logic       adjust,
   input  logic       select,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);

   logic [RW-1:0] rcnt;
   logic [1:0]    idx;
   logic [15:0]   snap;
   logic          tick;
   logic [6:0]    dec_seg;
   logic [3:0]    an_mask;

   assign tick = (rcnt == R_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rcnt <= '0;
         idx  <= DIG_SEC0;
         snap <= '0;
      end else begin
         rcnt <= tick ? '0 : rcnt + 1'b1;
         if (tick) begin
            idx <= idx + 2'd1;
            // The wrap from idx 3 starts a new frame, so all four digits are latched together.
            if (idx == DIG_MIN1)
               snap <= {min1, min0, sec1, sec0};
         end
      end
   end

   seg7_decode u_decode (
      .bcd (snap[{idx, 2'b00} +: 4]),
      .seg (dec_seg)
   );

`ifdef SEG7_BLINK_EN
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] bcnt;
   logic          phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (bcnt == B_LAST) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt  <= bcnt + 1'b1;
      end
   end

   always_comb begin
      an_mask = 4'b0000;
      if (adjust && phase)
         an_mask = select ? 4'b0011 : 4'b1100;
   end
`else
   logic unused_blink_inputs;
   assign unused_blink_inputs = adjust ^ select;
   assign an_mask = 4'b0000;
`endif

   // NOTE: the output register is reset asynchronously, so asserting reset blanks the display before the next clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= SEG_BLANK;
         dp  <= 1'b1;
         an  <= 4'b1111;
      end else begin
         seg <= dec_seg;
         dp  <= (idx != DIG_MIN0);
         an  <= anode_for(idx) | an_mask;
      end
   end

endmodule

// File: tb/tb_seg7_display_mux.sv
// Directed testbench for seg7_display_mux, run with REFRESH_DIV=4 and BLINK_DIV=8.
// The blink expectations follow SEG7_BLINK_EN, which must match the RTL build.
module tb_seg7_display_mux;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] min1, min0, sec1, sec0;
   logic       adjust, select;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   int n_cmp = 0;
   int n_err = 0;
   int k = 0;   // clock edges since the last reset release

   seg7_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .min1   (min1),
      .min0   (min0),
      .sec1   (sec1),
      .sec0   (sec0),
      .adjust (adjust),
      .select (select),
      .seg    (seg),
      .dp     (dp),
      .an     (an)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   task automatic test_reset();
      reset = 1'b1; adjust = 1'b0; select = 1'b0;
      min1 = 4'd1; min0 = 4'd2; sec1 = 4'd3; sec0 = 4'd4;
      step(); step();
      n_cmp++;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
         n_err++;
         $display("FAIL reset_hold: an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", an, seg, dp);
      end
      reset = 1'b0;
      k = 0;
      step();
      n_cmp++;
      if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
         n_err++;
         $display("FAIL first_edge: an=%b seg=%b dp=%b, want an=1110 seg=1000000 dp=1", an, seg, dp);
      end
      run_to(9);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1011, 7'b1000000, 1'b0}) begin
         n_err++;
         $display("FAIL pre_snapshot_min0: an=%b seg=%b dp=%b, want an=1011 seg=1000000 dp=0", an, seg, dp);
      end
      run_to(17);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1110, 7'b0011001, 1'b1}) begin
         n_err++;
         $display("FAIL frame1_sec0: an=%b seg=%b dp=%b, want an=1110 seg=0011001 dp=1", an, seg, dp);
      end
      run_to(21);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1101, 7'b0110000, 1'b1}) begin
         n_err++;
         $display("FAIL frame1_sec1: an=%b seg=%b dp=%b, want an=1101 seg=0110000 dp=1", an, seg, dp);
      end
   endtask

   task automatic test_snapshot();
      // Change the inputs mid-frame while idx=1. Only the next frame may show the new values.
      sec0 = 4'd9; min1 = 4'd5;
      run_to(25);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1011, 7'b0100100, 1'b0}) begin
         n_err++;
         $display("FAIL frame1_min0_dp: an=%b seg=%b dp=%b, want an=1011 seg=0100100 dp=0", an, seg, dp);
      end
      run_to(29);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0111, 7'b1111001, 1'b1}) begin
         n_err++;
         $display("FAIL snapshot_hold_min1: an=%b seg=%b dp=%b, want an=0111 seg=1111001 dp=1", an, seg, dp);
      end
      run_to(33);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1110, 7'b0010000, 1'b1}) begin
         n_err++;
         $display("FAIL snapshot_new_sec0: an=%b seg=%b dp=%b, want an=1110 seg=0010000 dp=1", an, seg, dp);
      end
      run_to(45);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0111, 7'b0010010, 1'b1}) begin
         n_err++;
         $display("FAIL snapshot_new_min1: an=%b seg=%b dp=%b, want an=0111 seg=0010010 dp=1", an, seg, dp);
      end
   endtask

   task automatic test_blank();
      min1 = 4'hC;
      run_to(49);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1110, 7'b0010000, 1'b1}) begin
         n_err++;
         $display("FAIL blank_other_sec0: an=%b seg=%b dp=%b, want an=1110 seg=0010000 dp=1", an, seg, dp);
      end
      run_to(57);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1011, 7'b0100100, 1'b0}) begin
         n_err++;
         $display("FAIL blank_other_min0: an=%b seg=%b dp=%b, want an=1011 seg=0100100 dp=0", an, seg, dp);
      end
      run_to(61);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0111, 7'b1111111, 1'b1}) begin
         n_err++;
         $display("FAIL blank_min1: an=%b seg=%b dp=%b, want an=0111 seg=1111111 dp=1", an, seg, dp);
      end
      run_to(64);
      n_cmp++;
      if ({an, seg, dp} !== {4'b0111, 7'b1111111, 1'b1}) begin
         n_err++;
         $display("FAIL blank_min1_last: an=%b seg=%b dp=%b, want an=0111 seg=1111111 dp=1", an, seg, dp);
      end
   endtask

   task automatic test_mid_reset();
      run_to(73);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1011, 7'b0100100, 1'b0}) begin
         n_err++;
         $display("FAIL pre_reset_min0: an=%b seg=%b dp=%b, want an=1011 seg=0100100 dp=0", an, seg, dp);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
         n_err++;
         $display("FAIL async_reset: an=%b seg=%b dp=%b, want an=1111 seg=1111111 dp=1", an, seg, dp);
      end
      step();
      reset = 1'b0;
      k = 0;
      step();
      n_cmp++;
      if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
         n_err++;
         $display("FAIL restart_idx0: an=%b seg=%b dp=%b, want an=1110 seg=1000000 dp=1", an, seg, dp);
      end
      run_to(5);
      n_cmp++;
      if ({an, seg, dp} !== {4'b1101, 7'b1000000, 1'b1}) begin
         n_err++;
         $display("FAIL restart_idx1: an=%b seg=%b dp=%b, want an=1101 seg=1000000 dp=1", an, seg, dp);
      end
   endtask

   // The blink phase is 0 for edges 0..7 after reset and 1 for edges 8..15, and so on.
   // The output after edge k reflects idx and phase as they stood after edge k-1.
   task automatic test_blink();
      logic [3:0] exp_an;
      int oi;
      int ph;
      adjust = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         select = (pass == 0);
         for (int n = 0; n < 32; n++) begin
            step();
            oi = ((k - 1) / 4) % 4;
            ph = ((k - 1) / 8) % 2;
            exp_an = 4'b1111;
            exp_an[oi] = 1'b0;
`ifdef SEG7_BLINK_EN
            if (ph == 1)
               exp_an = exp_an | (select ? 4'b0011 : 4'b1100);
`endif
            n_cmp++;
            if (an !== exp_an) begin
               n_err++;
               $display("FAIL blink_an k=%0d sel=%b phase=%0d: an=%b, want %b", k, select, ph, an, exp_an);
            end
         end
      end
      adjust = 1'b0;
   endtask

   initial begin
      test_reset();
      test_snapshot();
      test_blank();
      test_mid_reset();
      test_blink();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
